des_key_scheduler: RTL and testbench
====================================

# des_key_scheduler

Sequences DES subkey generation. Accepts a 64-bit key over a valid/ready handshake, applies PC-1, then produces the 16 48-bit round subkeys, one per accepted output beat. Subkeys come out in encrypt order (K1..K16) or decrypt order (K16..K1). Sits between the key register and the round datapath of the DES core and is the only consumer of the PC-1 block initialKeyPerm.

## Interface
- No parameters. Geometry is fixed by DES: 64-bit key, 56-bit CD, 48-bit subkey, 16 rounds.
- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- key_valid  in  1  key offer.
- key_ready  out  1  high only in IDLE.
- key  in  [1:64]  DES bit numbering (bit 1 = MSB). Parity bits 8,16,…,64 are ignored.
- decrypt  in  1  sampled with key: 0 = K1→K16, 1 = K16→K1.
- subkey_valid  out  1  subkey beat valid.
- subkey_ready  in  1  consumer accepts beat.
- subkey  out  [1:48]  PC-2 of current C/D.
- round  out  [3:0]  beat index in output order, 0..15.
- last  out  1  high with beat 15.
- busy  out  1  high when not IDLE.

## Operation
- States: IDLE, RUN.
- Registers: C[1:28], D[1:28], cnt[3:0], dir.
- IDLE: key_ready=1, subkey_valid=0.
  - On key_valid & key_ready: C/D ← PC-1(key) halves (bits 1–28 / 29–56); dir ← decrypt; cnt ← 0; go to RUN.
  - Encrypt load: C/D rotated left by 1 (C1D1).
  - Decrypt load: C/D unrotated (C0D0 = C16D16).
- RUN: subkey_valid=1, subkey = PC-2(C,D), round = cnt, last = (cnt==15).
  - On subkey_valid & subkey_ready with cnt<15: cnt+1.
    - Encrypt: C/D each rotate left by SHIFT[cnt+2].
    - Decrypt: C/D each rotate right by SHIFT[16−cnt].
  - On accept with cnt==15: go to IDLE. C/D are don't-care.
- SHIFT[n] (n = 1..16) = 1 for n ∈ {1,2,9,16}, else 2. Total shift is 28, so CD wraps to its original value.
- Rotations act independently on each 28-bit half. No bits cross between C and D.
- key_valid is ignored while in RUN. There is no key preemption: a new key waits for IDLE.
- decrypt is ignored except on the key-accept cycle.

## Timing
- Reset: state IDLE, key_ready=1, busy=0, subkey_valid=0, last=0, round=0, C/D/cnt=0, so subkey=PC-2(0)=0.
- Reset mid-RUN: the next edge with rst_n=0 discards the sequence and returns to IDLE with the values above. No further beats are presented.
- Latency: key accepted at edge T → subkey_valid=1 with round 0 from T+1.
- Throughput: one subkey per cycle while subkey_ready=1, so 16 beats occupy cycles T+1..T+16.
- The last accept at edge E moves the block to IDLE; key_ready=1 in cycle E+1. Minimum key-to-key spacing is 17 cycles.
- Backpressure: while subkey_valid & !subkey_ready, subkey/round/last are held stable. No state changes.
- subkey, round and last are combinational from registers. Inputs have no combinational path to outputs except via state.

## Structure
- Package des_pkg:
  - SHIFT schedule constant.
  - PC-2 index table (48 entries).
  - State enum {IDLE, RUN}.
  - Widths KEY_W=64, CD_W=56, HALF_W=28, SUBKEY_W=48.
- Instantiates initialKeyPerm for PC-1.
- One natural sub-module: des_pc2_perm, purely combinational, [1:56] → [1:48] via the des_pkg table.
- Rotate-by-1/2-left/right helpers are package functions.

## Test plan
- Encrypt vector: key 133457799BBCDFF1, decrypt=0, subkey_ready held 1.
  - Required: beat 0 = 1B02EFFC7072, beat 1 = 79AED9DBC9E5, beat 15 = CB3D8B0E17F5 with last=1.
  - Exactly 16 beats on consecutive cycles; key_ready returns the cycle after beat 15.
- Decrypt order: same key, decrypt=1.
  - Required: beat 0 = CB3D8B0E17F5, beat 15 = 1B02EFFC7072.
  - Each beat n equals encrypt beat 15−n.
- Backpressure: subkey_ready random ~50%.
  - Required: subkey and round stable while stalled.
  - Sequence identical to the unstalled run; no beat dropped or duplicated.
- Parity and busy key offer: flip all parity bits of the vector → identical 16 subkeys.
  - Assert key_valid with a different key throughout RUN → ignored.
  - Required: the second key is accepted only in the first IDLE cycle.
- Reset mid-run: drop rst_n for 1 cycle after beat 7.
  - Required: next cycle subkey_valid=0, busy=0, key_ready=1, round=0.
  - A fresh key then yields a correct full sequence from beat 0.
- Reference model: random keys × both directions against a software DES key schedule.
  - Required: all beats match; output wraps CD to PC-1(key) after 16 shifts in both directions.

Source files
------------

// File: rtl/des_pkg.sv
// ============================================================================
// des_pkg : DES key-schedule geometry, shift schedule, PC-2 table, rotations
// Rev 1.0
// ============================================================================
`default_nettype none

package des_pkg;

  localparam int KEY_W    = 64;
  localparam int CD_W     = 56;
  localparam int HALF_W   = 28;
  localparam int SUBKEY_W = 48;

  // Bit n-1 holds SHIFT[n]: set = rotate by 1, clear = rotate by 2 (rounds 1,2,9,16 are single).
  localparam logic [15:0] SHIFT = 16'h8103;

  localparam int PC2_TABLE [1:SUBKEY_W] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  function automatic logic [1:HALF_W] rotl1(input logic [1:HALF_W] h);
    return {h[2:HALF_W], h[1]};
  endfunction

  function automatic logic [1:HALF_W] rotl2(input logic [1:HALF_W] h);
    return {h[3:HALF_W], h[1:2]};
  endfunction

  function automatic logic [1:HALF_W] rotr1(input logic [1:HALF_W] h);
    return {h[HALF_W], h[1:HALF_W-1]};
  endfunction

  function automatic logic [1:HALF_W] rotr2(input logic [1:HALF_W] h);
    return {h[HALF_W-1:HALF_W], h[1:HALF_W-2]};
  endfunction

endpackage

`default_nettype wire

// File: rtl/des_pc2_perm.sv
// ============================================================================
// des_pc2_perm : DES PC-2, purely combinational 56-bit C||D to 48-bit subkey
// Rev 1.0
// ============================================================================
`default_nettype none

module des_pc2_perm
  import des_pkg::*;
(
  input  logic [1:CD_W]     i_cd,
  output logic [1:SUBKEY_W] o_subkey
);

  for (genvar i = 1; i <= SUBKEY_W; i++) begin : g_pc2
    assign o_subkey[i] = i_cd[PC2_TABLE[i]];
  end

  // The eight C||D positions PC-2 discards.
  logic w_unusedCd;
  assign w_unusedCd = ^{i_cd[9], i_cd[18], i_cd[22], i_cd[25],
                        i_cd[35], i_cd[38], i_cd[43], i_cd[54]};

endmodule

`default_nettype wire

// File: rtl/initialKeyPerm.sv
// ============================================================================
// initialKeyPerm : DES PC-1, 64-bit key to 56-bit C||D (parity bits dropped)
// Rev 1.0
// ============================================================================
`default_nettype none

module initialKeyPerm
  import des_pkg::*;
(
  input  logic [1:KEY_W] i_key,
  output logic [1:CD_W]  o_cd
);

  localparam int c_PC1 [1:CD_W] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  for (genvar i = 1; i <= CD_W; i++) begin : g_pc1
    assign o_cd[i] = i_key[c_PC1[i]];
  end

  // Parity bits never reach C||D.
  logic w_unusedParity;
  assign w_unusedParity = ^{i_key[8], i_key[16], i_key[24], i_key[32],
                            i_key[40], i_key[48], i_key[56], i_key[64]};

endmodule

`default_nettype wire

// File: rtl/des_key_scheduler.sv
// ============================================================================
// des_key_scheduler : streams the 16 DES round subkeys in encrypt/decrypt order
// Rev 1.0
// ============================================================================
`default_nettype none

module des_key_scheduler
  import des_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                key_valid,
  output logic                key_ready,
  input  logic [1:KEY_W]      key,
  input  logic                decrypt,
  output logic                subkey_valid,
  input  logic                subkey_ready,
  output logic [1:SUBKEY_W]   subkey,
  output logic [3:0]          round,
  output logic                last,
  output logic                busy
);

  state_t             r_state;
  logic [1:HALF_W]    r_c;
  logic [1:HALF_W]    r_d;
  logic [3:0]         r_cnt;
  logic               r_dir;

  logic [1:CD_W]      w_pc1;
  logic [1:HALF_W]    w_cNext;
  logic [1:HALF_W]    w_dNext;
  logic [3:0]         w_shiftIdx;
  logic               w_shiftOne;

  initialKeyPerm u_pc1 (
    .i_key (key),
    .o_cd  (w_pc1)
  );

  des_pc2_perm u_pc2 (
    .i_cd     ({r_c, r_d}),
    .o_subkey (subkey)
  );

  // Encrypt advances with SHIFT[cnt+2]; decrypt undoes SHIFT[16-cnt], i.e. bit ~cnt.
  always_comb begin
    w_shiftIdx = r_dir ? ~r_cnt : r_cnt + 4'd1;
    w_shiftOne = SHIFT[w_shiftIdx];
    if (r_dir) begin
      w_cNext = w_shiftOne ? rotr1(r_c) : rotr2(r_c);
      w_dNext = w_shiftOne ? rotr1(r_d) : rotr2(r_d);
    end else begin
      w_cNext = w_shiftOne ? rotl1(r_c) : rotl2(r_c);
      w_dNext = w_shiftOne ? rotl1(r_d) : rotl2(r_d);
    end
  end

  assign key_ready    = (r_state == IDLE);
  assign busy         = (r_state == RUN);
  assign subkey_valid = busy;
  assign round        = r_cnt;
  assign last         = busy && (r_cnt == 4'd15);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_c     <= '0;
      r_d     <= '0;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (key_valid) begin
            r_state <= RUN;
            r_dir   <= decrypt;
            r_cnt   <= '0;
            // Decrypt starts from C0D0, which equals C16D16 since the shifts total 28.
            r_c     <= decrypt ? w_pc1[1:HALF_W]      : rotl1(w_pc1[1:HALF_W]);
            r_d     <= decrypt ? w_pc1[HALF_W+1:CD_W] : rotl1(w_pc1[HALF_W+1:CD_W]);
          end
        end
        RUN: begin
          if (subkey_ready) begin
            if (r_cnt == 4'd15) begin
              r_state <= IDLE;
              r_cnt   <= '0;
            end else begin
              r_cnt   <= r_cnt + 4'd1;
              r_c     <= w_cNext;
              r_d     <= w_dNext;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_des_key_scheduler.sv
// ============================================================================
// tb_des_key_scheduler : directed + randomized checks against a DES schedule model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_des_key_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        key_valid = 1'b0;
  logic        decrypt = 1'b0;
  logic        subkey_ready = 1'b0;
  logic [63:0] key = '0;
  logic        key_ready;
  logic        subkey_valid;
  logic        last;
  logic        busy;
  logic [47:0] subkey;
  logic [3:0]  round;

  int nVec = 0;
  int nMis = 0;

  logic [47:0] expK [16];

  localparam logic [63:0] c_KV     = 64'h133457799BBCDFF1;
  localparam logic [63:0] c_PARITY = 64'h0101010101010101;

  int pc1Tab [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4};
  int pc2Tab [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  int shiftTab [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  always #5 clk = ~clk;

  des_key_scheduler dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_valid    (key_valid),
    .key_ready    (key_ready),
    .key          (key),
    .decrypt      (decrypt),
    .subkey_valid (subkey_valid),
    .subkey_ready (subkey_ready),
    .subkey       (subkey),
    .round        (round),
    .last         (last),
    .busy         (busy)
  );

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    nVec++;
    assert (obs === expv) else begin
      nMis++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // Key schedule from first principles: cumulative left rotation of C0/D0 modulo 28.
  task automatic buildModel(input logic [63:0] k, input bit dec);
    logic [1:56] cd0;
    logic [1:56] cdn;
    logic [47:0] kn [16];
    int s;
    for (int i = 0; i < 56; i++) cd0[i+1] = k[64 - pc1Tab[i]];
    s = 0;
    for (int n = 0; n < 16; n++) begin
      s += shiftTab[n];
      for (int i = 0; i < 28; i++) begin
        cdn[i+1]  = cd0[((i + s) % 28) + 1];
        cdn[i+29] = cd0[((i + s) % 28) + 29];
      end
      for (int j = 0; j < 48; j++) kn[n][47-j] = cdn[pc2Tab[j]];
    end
    for (int b = 0; b < 16; b++) expK[b] = dec ? kn[15-b] : kn[b];
  endtask

  task automatic startKey(input logic [63:0] k, input bit dec, input string tag);
    int w;
    w = 0;
    key = k;
    decrypt = dec;
    key_valid = 1'b1;
    while (key_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    if (w >= 50) begin
      nVec++;
      nMis++;
      $error("FAIL %s/accept: observed key_ready %b expected 1 within 50 cycles", tag, key_ready);
    end
    @(negedge clk);
    key_valid = 1'b0;
    decrypt = 1'($urandom_range(0, 1));
    key = {$urandom, $urandom};
    check({tag, "/busy"}, 64'(busy), 64'd1);
  endtask

  task automatic drain(input int nBeats, input bit rnd, input string tag);
    int beat;
    int cyc;
    beat = 0;
    cyc = 0;
    while (beat < nBeats) begin
      if (cyc >= 400) begin
        nVec++;
        nMis++;
        $error("FAIL %s/timeout: observed %0d beats expected %0d", tag, beat, nBeats);
        return;
      end
      check($sformatf("%s/valid%0d", tag, beat), 64'(subkey_valid), 64'd1);
      check($sformatf("%s/subkey%0d", tag, beat), 64'(subkey), 64'(expK[beat]));
      check($sformatf("%s/round%0d", tag, beat), 64'(round), 64'(beat[3:0]));
      check($sformatf("%s/last%0d", tag, beat), 64'(last), 64'(beat == 15));
      subkey_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (subkey_ready) beat++;
      cyc++;
      @(negedge clk);
    end
    if (nBeats == 16) begin
      subkey_ready = 1'b0;
      check({tag, "/readyAfter"}, 64'(key_ready), 64'd1);
      check({tag, "/validAfter"}, 64'(subkey_valid), 64'd0);
      check({tag, "/busyAfter"}, 64'(busy), 64'd0);
    end
  endtask

  initial begin
    logic [63:0] k2;
    logic [63:0] kr;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst/key_ready", 64'(key_ready), 64'd1);
    check("rst/busy", 64'(busy), 64'd0);
    check("rst/valid", 64'(subkey_valid), 64'd0);
    check("rst/last", 64'(last), 64'd0);
    check("rst/round", 64'(round), 64'd0);
    check("rst/subkey", 64'(subkey), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer vector, encrypt order; anchor beats taken from the published schedule.
    buildModel(c_KV, 1'b0);
    expK[0]  = 48'h1B02EFFC7072;
    expK[1]  = 48'h79AED9DBC9E5;
    expK[15] = 48'hCB3D8B0E17F5;
    startKey(c_KV, 1'b0, "enc");
    drain(16, 1'b0, "enc");

    // Same key, decrypt order.
    buildModel(c_KV, 1'b1);
    expK[0]  = 48'hCB3D8B0E17F5;
    expK[15] = 48'h1B02EFFC7072;
    startKey(c_KV, 1'b1, "dec");
    drain(16, 1'b0, "dec");

    // Random backpressure.
    buildModel(c_KV, 1'b0);
    startKey(c_KV, 1'b0, "bp");
    drain(16, 1'b1, "bp");

    // Parity bits flipped: subkeys of the unmodified key.
    buildModel(c_KV, 1'b0);
    startKey(c_KV ^ c_PARITY, 1'b0, "par");
    drain(16, 1'b0, "par");

    // A second key offered (with decrypt=1) throughout RUN is taken only at the first IDLE cycle.
    k2 = {$urandom, $urandom};
    buildModel(c_KV, 1'b0);
    startKey(c_KV, 1'b0, "busyA");
    key = k2;
    decrypt = 1'b1;
    key_valid = 1'b1;
    drain(16, 1'b0, "busyA");
    buildModel(k2, 1'b1);
    @(negedge clk);
    key_valid = 1'b0;
    decrypt = 1'b0;
    check("busyB/busy", 64'(busy), 64'd1);
    drain(16, 1'b0, "busyB");

    // Reset after beat 7.
    buildModel(c_KV, 1'b0);
    startKey(c_KV, 1'b0, "mid");
    drain(8, 1'b0, "mid");
    rst_n = 1'b0;
    subkey_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid/valid", 64'(subkey_valid), 64'd0);
    check("mid/busy", 64'(busy), 64'd0);
    check("mid/key_ready", 64'(key_ready), 64'd1);
    check("mid/round", 64'(round), 64'd0);
    kr = {$urandom, $urandom};
    buildModel(kr, 1'b0);
    startKey(kr, 1'b0, "post");
    drain(16, 1'b0, "post");

    // Random keys, both directions, with and without stalls.
    for (int i = 0; i < 8; i++) begin
      kr = {$urandom, $urandom};
      buildModel(kr, 1'(i % 2));
      startKey(kr, 1'(i % 2), $sformatf("rnd%0d", i));
      drain(16, 1'(i >= 4), $sformatf("rnd%0d", i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule

`default_nettype wire
